// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encodings and ALU in_sel controls for alu_op_sequencer.
// Rev 1.0
`default_nettype none
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // in_sel bit order is {persist, load, reset}
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_NONE    = 3'b000;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 6;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on a tie the requester that did not win last time wins.
// Rev 1.0
`default_nettype none
module rr_arb2
  import alu_seq_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = (valid0 && valid1) ? ~last_grant : valid1;
    grant    = 2'b00;
    if (enable && (valid0 || valid1)) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: shares one ALU between two requesters (load / persist / capture / respond).
// Rev 1.0 -- optional ALU_SEQ_STATS_EN adds per-requester completed-op counters.
`default_nettype none
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OP_W     = DEF_OP_W,
  parameter int EXEC_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [2:0]        alu_in_sel,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [OP_W-1:0]   alu_out_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       op_count0,
  output logic [15:0]       op_count1
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYC - 1);

  state_t            state, state_nxt;
  logic              last_grant, gid;
  logic [DATA_W-1:0] a_q, b_q, result;
  logic [OP_W-1:0]   op_q;
  logic [3:0]        cnt;
  logic [1:0]        grant;
  logic              grant_id;
  logic              accept, exec_done, resp_fire;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .enable     (state == ST_IDLE && !reset),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign accept    = |grant;
  assign exec_done = (state == ST_EXEC) && (cnt == LAST_CNT);
  assign resp_fire = (state == ST_RESP) && (gid ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_LOAD;
      ST_LOAD:                state_nxt = ST_EXEC;
      ST_EXEC: if (exec_done) state_nxt = ST_RESP;
      ST_RESP: if (resp_fire) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_in_sel  = SEL_NONE;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    if (reset) begin
      alu_in_sel = SEL_RESET;
    end else begin
      case (state)
        ST_LOAD: alu_in_sel = SEL_LOAD;
        ST_EXEC: alu_in_sel = SEL_PERSIST;
        ST_RESP: begin
          resp0_valid = !gid;
          resp1_valid = gid;
        end
        default: alu_in_sel = SEL_NONE;
      endcase
    end
  end

  // Operand registers only move on accept, so the ALU pins stay stable outside LOAD/EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result     <= '0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        a_q        <= grant_id ? req1_a  : req0_a;
        b_q        <= grant_id ? req1_b  : req0_b;
        op_q       <= grant_id ? req1_op : req0_op;
        gid        <= grant_id;
        last_grant <= grant_id;
      end
      if (state == ST_LOAD) cnt <= '0;
      if (state == ST_EXEC) cnt <= cnt + 4'd1;
      if (exec_done)        result <= alu_out;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_data  = result;
  assign resp1_data  = result;
  assign alu_num1    = a_q;
  assign alu_num2    = b_q;
  assign alu_out_sel = op_q;
  assign busy        = (state != ST_IDLE);

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count0 <= '0;
      op_count1 <= '0;
    end else if (resp_fire) begin
      if (!gid && op_count0 != 16'hFFFF) op_count0 <= op_count0 + 16'd1;
      if (gid  && op_count1 != 16'hFFFF) op_count1 <= op_count1 + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: instance 0 uses EXEC_CYC=1, instance 1 uses EXEC_CYC=4; both share stimulus.
// Rev 1.0
`default_nettype none
module tb_alu_op_sequencer;

  localparam int DW = 8;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;

  logic [1:0]    rq0_ready, rq1_ready, rs0_valid, rs1_valid, busy;
  logic [DW-1:0] rs0_data[2], rs1_data[2], num1[2], num2[2], alu_out[2];
  logic [2:0]    in_sel[2];
  logic [OW-1:0] out_sel[2];
  logic [15:0]   cnt0[2], cnt1[2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ECYC = (g == 0) ? 1 : 4;
    // Bench ALU: out = num1 + num2
    assign alu_out[g] = num1[g] + num2[g];
    alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .EXEC_CYC(ECYC)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (rq0_ready[g]),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .resp0_valid (rs0_valid[g]),
      .resp0_ready (resp0_ready),
      .resp0_data  (rs0_data[g]),
      .req1_valid  (req1_valid),
      .req1_ready  (rq1_ready[g]),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .resp1_valid (rs1_valid[g]),
      .resp1_ready (resp1_ready),
      .resp1_data  (rs1_data[g]),
      .alu_in_sel  (in_sel[g]),
      .alu_num1    (num1[g]),
      .alu_num2    (num2[g]),
      .alu_out_sel (out_sel[g]),
      .alu_out     (alu_out[g]),
      .busy        (busy[g])
`ifdef ALU_SEQ_STATS_EN
      ,
      .op_count0   (cnt0[g]),
      .op_count1   (cnt1[g])
`endif
    );
`ifndef ALU_SEQ_STATS_EN
    assign cnt0[g] = '0;
    assign cnt1[g] = '0;
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver only: issues one op on instance 0 and returns the response data.
  task automatic run_op(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [DW-1:0] d, output logic ok);
    logic acc;
    acc = 1'b0; ok = 1'b0; d = '0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int c = 0; c < 20 && !acc; c++) begin
      #1; acc = id ? rq1_ready[0] : rq0_ready[0];
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (id ? rs1_valid[0] : rs0_valid[0]) begin
        ok = acc; d = id ? rs1_data[0] : rs0_data[0];
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      total++; if (in_sel[g] !== 3'b001) $display("FAIL reset_in_sel[%0d]: got %b want 001", g, in_sel[g]); else passed++;
      total++; if (busy[g] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", g, busy[g]); else passed++;
      total++; if (rq0_ready[g] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", g, rq0_ready[g]); else passed++;
      total++; if (rs0_valid[g] !== 1'b0 || rs1_valid[g] !== 1'b0) $display("FAIL reset_resp_valid[%0d]: got %b%b want 00", g, rs0_valid[g], rs1_valid[g]); else passed++;
      total++; if (num1[g] !== 8'h00 || num2[g] !== 8'h00 || out_sel[g] !== 6'h00 || rs0_data[g] !== 8'h00)
        $display("FAIL reset_regs[%0d]: got %h %h %h %h want 0", g, num1[g], num2[g], out_sel[g], rs0_data[g]); else passed++;
    end
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0;
    #1;
    total++; if (in_sel[0] !== 3'b000) $display("FAIL idle_in_sel: got %b want 000", in_sel[0]); else passed++;
  endtask

  task automatic test_single_op();
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h1A; req0_op = 6'b000001;
    #1;
    total++; if (rq0_ready[0] !== 1'b1) $display("FAIL single_accept: got %b want 1", rq0_ready[0]); else passed++;
    @(negedge clk); req0_valid = 1'b0; #1;
    total++; if (in_sel[0] !== 3'b010) $display("FAIL single_load_sel: got %b want 010", in_sel[0]); else passed++;
    total++; if (num1[0] !== 8'h57 || num2[0] !== 8'h1A || out_sel[0] !== 6'b000001)
      $display("FAIL single_operands: got %h %h %b want 57 1a 000001", num1[0], num2[0], out_sel[0]); else passed++;
    @(negedge clk); #1;
    total++; if (in_sel[0] !== 3'b100 || rs0_valid[0] !== 1'b0) $display("FAIL single_persist: got %b v%b want 100 v0", in_sel[0], rs0_valid[0]); else passed++;
    @(negedge clk); #1;
    total++; if (rs0_valid[0] !== 1'b1 || rs0_data[0] !== 8'h71) $display("FAIL single_resp: got v%b %h want v1 71", rs0_valid[0], rs0_data[0]); else passed++;
    total++; if (rs1_valid[0] !== 1'b0 || in_sel[0] !== 3'b000) $display("FAIL single_resp_other: got v1=%b sel=%b want 0 000", rs1_valid[0], in_sel[0]); else passed++;
    @(negedge clk); #1;
    total++; if (busy[0] !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy[0]); else passed++;
  endtask

  task automatic test_contention();
    int n;
    logic expect_id;
    do_reset();
    n = 0; expect_id = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (rq0_ready[0] || rq1_ready[0]) begin
        total++;
        if ({rq1_ready[0], rq0_ready[0]} !== (expect_id ? 2'b10 : 2'b01))
          $display("FAIL contention_grant%0d: got %b%b want id %0d", n, rq1_ready[0], rq0_ready[0], expect_id);
        else passed++;
        expect_id = ~expect_id; n++;
      end
      @(negedge clk);
    end
    total++; if (n != 4) $display("FAIL contention_timeout: got %0d grants want 4", n); else passed++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] expv;
    logic found;
    do_reset();
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom);
    expv = req1_a + req1_b;
    #1;
    total++; if (rq1_ready[0] !== 1'b1) $display("FAIL bp_accept: got %b want 1", rq1_ready[0]); else passed++;
    @(negedge clk); req1_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (rs1_valid[0]) found = 1'b1;
      else @(negedge clk);
    end
    total++; if (!found) $display("FAIL bp_resp_timeout: got no resp1_valid want 1"); else passed++;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (rs1_valid[0] !== 1'b1 || rs1_data[0] !== expv) $display("FAIL bp_hold%0d: got v%b %h want v1 %h", i, rs1_valid[0], rs1_data[0], expv); else passed++;
      total++; if (busy[0] !== 1'b1) $display("FAIL bp_busy%0d: got %b want 1", i, busy[0]); else passed++;
      total++; if (rq0_ready[0] !== 1'b0 || rq1_ready[0] !== 1'b0) $display("FAIL bp_no_accept%0d: got %b%b want 00", i, rq1_ready[0], rq0_ready[0]); else passed++;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp1_ready = 1'b1;
    #1;
    @(negedge clk); #1;
    total++; if (busy[0] !== 1'b0 || in_sel[0] !== 3'b000) $display("FAIL bp_release: got busy %b sel %b want 0 000", busy[0], in_sel[0]); else passed++;
  endtask

  task automatic test_exec4();
    logic [DW-1:0] expv;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom);
    expv = req0_a + req0_b;
    #1;
    total++; if (rq0_ready[1] !== 1'b1) $display("FAIL exec4_accept: got %b want 1", rq0_ready[1]); else passed++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); req0_valid = 1'b0; #1;
      total++;
      if (in_sel[1] !== ((k == 1) ? 3'b010 : (k <= 5) ? 3'b100 : 3'b000))
        $display("FAIL exec4_sel_t%0d: got %b", k, in_sel[1]);
      else passed++;
      total++; if (rs0_valid[1] !== (k == 6)) $display("FAIL exec4_valid_t%0d: got %b want %b", k, rs0_valid[1], (k == 6)); else passed++;
    end
    total++; if (rs0_data[1] !== expv) $display("FAIL exec4_data: got %h want %h", rs0_data[1], expv); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic ok;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h05;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (in_sel[0] !== 3'b001 || in_sel[1] !== 3'b001) $display("FAIL midrst_sel: got %b %b want 001", in_sel[0], in_sel[1]); else passed++;
    @(negedge clk); reset = 1'b0; #1;
    total++; if (busy !== 2'b00 || in_sel[0] !== 3'b000) $display("FAIL midrst_idle: got busy %b sel %b want 00 000", busy, in_sel[0]); else passed++;
    for (int c = 0; c < 6; c++) begin
      total++; if ((rs0_valid | rs1_valid) !== 2'b00) $display("FAIL midrst_noresp%0d: got %b want 00", c, rs0_valid | rs1_valid); else passed++;
      @(negedge clk); #1;
    end
    run_op(1'b1, 8'hC3, 8'h4A, d, ok);
    total++; if (!ok || d !== 8'h0D) $display("FAIL midrst_next_op: got ok%b %h want ok1 0d", ok, d); else passed++;
  endtask

  // Transaction-level model for instance 0: one op in flight, response 2+EXEC_CYC cycles after accept.
  task automatic test_random();
    logic m_busy, m_id, m_last, w, e_r0, e_r1, e_v0, e_v1, acc0, acc1;
    int m_wait;
    logic [DW-1:0] m_data;
    do_reset();
    m_busy = 1'b0; m_id = 1'b0; m_last = 1'b1; m_wait = 0; m_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 6'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 6'($urandom);
      end
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      e_r0 = 1'b0; e_r1 = 1'b0; w = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0 = !w; e_r1 = w;
      end
      e_v0 = m_busy && m_wait == 0 && !m_id;
      e_v1 = m_busy && m_wait == 0 && m_id;
      #1;
      total++; if ({rq1_ready[0], rq0_ready[0]} !== {e_r1, e_r0}) $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, rq1_ready[0], rq0_ready[0], e_r1, e_r0); else passed++;
      total++; if ({rs1_valid[0], rs0_valid[0]} !== {e_v1, e_v0}) $display("FAIL rand_valid c%0d: got %b%b want %b%b", c, rs1_valid[0], rs0_valid[0], e_v1, e_v0); else passed++;
      if (e_v0 || e_v1) begin
        total++; if ((m_id ? rs1_data[0] : rs0_data[0]) !== m_data) $display("FAIL rand_data c%0d: got %h want %h", c, m_id ? rs1_data[0] : rs0_data[0], m_data); else passed++;
      end
      acc0 = e_r0; acc1 = e_r1;
      if (m_busy && m_wait > 0) m_wait--;
      else if (m_busy && (m_id ? resp1_ready : resp0_ready)) m_busy = 1'b0;
      if (e_r0 || e_r1) begin
        m_busy = 1'b1; m_id = w; m_last = w; m_wait = 2;
        m_data = w ? req1_a + req1_b : req0_a + req0_b;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
  endtask

  task automatic test_stats();
    logic [DW-1:0] d;
    logic ok;
    do_reset();
    #1;
    total++; if (cnt0[0] !== 16'd0 || cnt1[0] !== 16'd0) $display("FAIL stats_init: got %0d %0d want 0 0", cnt0[0], cnt1[0]); else passed++;
    for (int i = 0; i < 3; i++) run_op(1'b0, 8'(i), 8'd1, d, ok);
    for (int i = 0; i < 2; i++) run_op(1'b1, 8'(i), 8'd2, d, ok);
    #1;
    total++; if (cnt0[0] !== 16'd3 || cnt1[0] !== 16'd2) $display("FAIL stats_count: got %0d %0d want 3 2", cnt0[0], cnt1[0]); else passed++;
    do_reset();
    #1;
    total++; if (cnt0[0] !== 16'd0 || cnt1[0] !== 16'd0) $display("FAIL stats_clear: got %0d %0d want 0 0", cnt0[0], cnt1[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_back_pressure();
    test_exec4();
    test_reset_mid();
    test_random();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Shares the single 8-bit ALU (`main`) between two requesters. Each requester issues an operation: operand A, operand B and an op select.
- A round-robin arbiter grants one request at a time. The block then sequences the ALU's load, persist and reset controls, captures the ALU output and returns it to the requester over a valid/ready handshake.
- Sits directly between request sources and the ALU's in_sel/num1/num2/out_sel/out pins.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 6, ALU op-select width (drives out_sel).
- EXEC_CYC, 1, number of persist cycles before capture; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  DATA_W  operand A
- req0_b  in  DATA_W  operand B
- req0_op  in  OP_W  op select
- resp0_valid  out  1  result for requester 0 valid
- resp0_ready  in  1  requester 0 takes result
- resp0_data  out  DATA_W  result
- req1_*/resp1_*  as requester 0, for requester 1
- alu_in_sel  out  3  {persist, load, reset} to ALU
- alu_num1  out  DATA_W  ALU operand 1
- alu_num2  out  DATA_W  ALU operand 2
- alu_out_sel  out  OP_W  ALU op select
- alu_out  in  DATA_W  ALU result
- busy  out  1  state != IDLE

Behaviour:
- **States** (2-bit): IDLE=00, LOAD=01, EXEC=10, RESP=11.
- **Reset:**
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - alu_in_sel=3'b001 while reset is high. It is 3'b000 in IDLE after reset.
  - All other outputs, plus the held operand and result registers, are 0.
- **IDLE:**
  - reqN_ready=1 only for the arbiter winner, and only while IDLE. Ready is combinational from valid and last_grant.
  - Arbitration: if one requester is valid, it wins. If both are valid, the requester that is not last_grant wins.
  - On valid&&ready: latch a, b, op and grant id into registers; last_grant<=id; next state LOAD.
- **LOAD** (1 cycle): alu_in_sel=3'b010, with alu_num1/num2/out_sel driven from the latched registers. Next state EXEC; exec counter=0.
- **EXEC:**
  - alu_in_sel=3'b100 (persist); operands stay held; counter increments each cycle.
  - On the cycle where counter==EXEC_CYC-1: latch result<=alu_out; next state RESP.
- **RESP:**
  - alu_in_sel=3'b000. respN_valid=1 for the granted id only; respN_data=result, held stable until respN_ready.
  - On valid&&ready: next state IDLE. The next grant can be accepted in the IDLE cycle that follows; there is no back-to-back accept from RESP.
- **Latency:** request accepted at cycle T gives resp_valid at T+2+EXEC_CYC.
- **Operand outputs:** alu_num1/num2/out_sel hold their last latched values outside LOAD/EXEC. They change only on accept.
- **Response back-pressure:** a requester may raise a new req while its own response is pending; it is not accepted until IDLE.
- **Reset mid-operation:** any state returns to IDLE; the in-flight result is dropped with no response; alu_in_sel=001 while reset is high.
- **Op width:** op is passed through unchanged; no legality check on op.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, adds outputs op_count0 and op_count1, 16 bits each.
  - The counter increments on each completed response handshake for that requester.
  - It saturates at 16'hFFFF and is cleared by reset.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - state encodings (IDLE/LOAD/EXEC/RESP);
  - in_sel constants: SEL_RESET=3'b001, SEL_LOAD=3'b010, SEL_PERSIST=3'b100, SEL_NONE=3'b000;
  - default DATA_W/OP_W.
- One sub-module, rr_arb2: 2-input round-robin arbiter. Inputs: two valids, enable, last_grant. Outputs: one-hot grant and grant id.

Test Plan:
- **Single op:** bench ALU model gives out=num1+num2. req0 a=8'h57, b=8'h1A, op=6'b000001, EXEC_CYC=1.
  - Required: LOAD cycle shows in_sel=010 with num1=57, num2=1A.
  - Then one cycle of in_sel=100.
  - resp0_valid at T+3 with data=8'h71.
- **Contention:** both requesters valid at the first cycle after reset.
  - Required: req0 granted first.
  - With both still valid afterwards, req1 granted next, then req0: strict alternation.
- **Back-pressure:** hold resp1_ready=0 for 5 cycles.
  - Required: resp1_valid and data held stable; busy=1; no req accepted.
  - Release: IDLE next cycle.
- **EXEC_CYC=4:** required exactly 4 persist cycles; result captured on the 4th; resp at T+6.
- **Reset during EXEC:**
  - Required: alu_in_sel=001 during reset.
  - After reset: IDLE, no resp asserted, and the next op completes correctly.
- **ALU_SEQ_STATS_EN:** run 3 req0 ops and 2 req1 ops.
  - Required: op_count0=3, op_count1=2.
  - Reset clears both counters to 0.
